cordic_hyp_rom_addr_gen: RTL and testbench

// - Front-end of the hyperbolic CORDIC pipeline. Sits directly upstream of the ROM-output buffer stage.
// - Accepts one signed (x,y) sample and folds it into the first octant, recording the fold as index_qua.
// - Normalises the folded pair with a bit-serial left shift, then issues the 48-bit coefficient-ROM read.
// - Presents wen/index_qua/index_cor time-aligned with the ROM data word Q.

---
 rtl/cordic_hyp_pkg.sv | 40 ++++
 rtl/cordic_hyp_delay_line.sv | 23 ++
 rtl/cordic_hyp_rom_addr_gen.sv | 123 ++++++++++++
 tb/tb_cordic_hyp_rom_addr_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_hyp_pkg.sv
// Shared types and constants for the hyperbolic CORDIC front-end.
// The fold/normalise datapath assumes a 16-bit sample and a 2 x 5-bit ROM address.
package cordic_hyp_pkg;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 10;
  localparam int MAG_W   = DATA_W - 1;
  localparam int FIELD_W = ADDR_W / 2;
  localparam int CNT_W   = 4;
  localparam int QUA_W   = 3;
  localparam int COR_W   = 7;

  localparam int SX = 2;
  localparam int SY = 1;
  localparam int SW = 0;

  localparam logic [MAG_W-1:0] SAT_MAX   = 15'h7FFF;
  localparam logic [CNT_W-1:0] MAX_SHIFT = 4'(MAG_W - 1);

  typedef enum logic [1:0] {IDLE, NORM, ISSUE} state_t;

  typedef struct packed {
    logic             vld;
    logic [QUA_W-1:0] qua;
    logic [COR_W-1:0] cor;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // |v| on MAG_W bits; the most negative code has no positive twin, so it clips.
  function automatic logic [MAG_W-1:0] abs_sat(input logic [DATA_W-1:0] v);
    logic [MAG_W-1:0] mag;
    if (!v[DATA_W-1])
      mag = v[MAG_W-1:0];
    else if (v[MAG_W-1:0] == '0)
      mag = SAT_MAX;
    else
      mag = ~v[MAG_W-1:0] + 1'b1;
    return mag;
  endfunction
endpackage

// File: rtl/cordic_hyp_delay_line.sv
// Resettable shift register; carries the sample tag across the ROM read latency.
module cordic_hyp_delay_line #(
  parameter int W     = 11,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout
);
  logic [W-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_dout = r_pipe[DEPTH-1];
endmodule

// File: rtl/cordic_hyp_rom_addr_gen.sv
// Folds a signed (x,y) into the first octant, normalises it bit-serially and issues the ROM read;
// wen/index_* arrive ROM_LAT cycles after rom_en, aligned with the ROM data word.
module cordic_hyp_rom_addr_gen
  import cordic_hyp_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              wen,
  output logic [QUA_W-1:0]  index_qua,
  output logic [COR_W-1:0]  index_cor
);
  state_t           r_state, w_next;
  logic [MAG_W-1:0] r_a, r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [QUA_W-1:0] r_qua;

  logic              r_rom_en, r_wen;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [QUA_W-1:0]  r_index_qua;
  logic [COR_W-1:0]  r_index_cor;

  logic [MAG_W-1:0] w_ax, w_ay;
  logic             w_swap, w_accept, w_norm_done, w_issue;
  tag_t             w_tag_in, w_tag_out;

  assign w_ax        = abs_sat(x_in);
  assign w_ay        = abs_sat(y_in);
  assign w_swap      = (w_ay > w_ax);
  assign w_norm_done = r_a[MAG_W-1] || (r_a == '0) || (r_cnt == MAX_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = NORM;
      NORM:    if (w_norm_done) w_next = ISSUE;
      ISSUE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE);
    w_issue  = (r_state == ISSUE);
    w_accept = in_ready && in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_qua <= '0;
    end else if (w_accept) begin
      r_a        <= w_swap ? w_ay : w_ax;
      r_b        <= w_swap ? w_ax : w_ay;
      r_cnt      <= '0;
      r_qua[SX]  <= x_in[DATA_W-1];
      r_qua[SY]  <= y_in[DATA_W-1];
      r_qua[SW]  <= w_swap;
    end else if (r_state == NORM && !w_norm_done) begin
      r_a   <= r_a << 1;
      r_b   <= r_b << 1;
      r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rom_en   <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_rom_en <= w_issue;
      if (w_issue) r_rom_addr <= {r_a[MAG_W-1 -: FIELD_W], r_b[MAG_W-1 -: FIELD_W]};
    end
  end

  // Tag enters the delay line on the same edge that raises rom_en; the extra
  // output register below makes up the final stage so wen lands ROM_LAT after rom_en.
  assign w_tag_in = '{vld: w_issue, qua: r_qua, cor: {r_cnt, r_b[MAG_W-FIELD_W-1 -: 3]}};

  cordic_hyp_delay_line #(
    .W     (TAG_W),
    .DEPTH (ROM_LAT)
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .i_din  (w_tag_in),
    .o_dout (w_tag_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wen       <= 1'b0;
      r_index_qua <= '0;
      r_index_cor <= '0;
    end else begin
      r_wen <= w_tag_out.vld;
      if (w_tag_out.vld) begin
        r_index_qua <= w_tag_out.qua;
        r_index_cor <= w_tag_out.cor;
      end
    end
  end

  assign rom_en    = r_rom_en;
  assign rom_addr  = r_rom_addr;
  assign wen       = r_wen;
  assign index_qua = r_index_qua;
  assign index_cor = r_index_cor;
endmodule

// File: tb/tb_cordic_hyp_rom_addr_gen.sv
// Scoreboard bench for cordic_hyp_rom_addr_gen: expected ROM address, tag and timing
// are queued on accept and checked when rom_en / wen appear.
module tb_cordic_hyp_rom_addr_gen;
  localparam int ROM_LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic        wen;
  logic [2:0]  index_qua;
  logic [6:0]  index_cor;

  cordic_hyp_rom_addr_gen #(.ROM_LAT(ROM_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .wen       (wen),
    .index_qua (index_qua),
    .index_cor (index_cor)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         acc;
    int         n;
    logic [9:0] addr;
    logic [2:0] qua;
    logic [6:0] cor;
  } exp_t;

  exp_t rq[$];
  exp_t wq[$];

  int         total = 0;
  int         bad = 0;
  bit         mon_on = 1'b0;
  int         busy_until = 0;
  bit         prev_wen = 1'b0;
  logic [2:0] last_qua = '0;
  logic [6:0] last_cor = '0;
  int         rom_cnt = 0;
  int         wen_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                output logic [9:0] addr, output logic [2:0] qua,
                                output logic [6:0] cor, output int n);
    logic [15:0] nx, ny;
    logic [14:0] ax, ay, a, b;
    logic        sw;
    nx = -x;
    ny = -y;
    ax = !x[15] ? x[14:0] : (x == 16'h8000) ? 15'h7FFF : nx[14:0];
    ay = !y[15] ? y[14:0] : (y == 16'h8000) ? 15'h7FFF : ny[14:0];
    sw = (ay > ax);
    a  = sw ? ay : ax;
    b  = sw ? ax : ay;
    n  = 0;
    while (!a[14] && a != 0 && n < 14) begin
      a = a << 1;
      b = b << 1;
      n++;
    end
    addr = {a[14:10], b[14:10]};
    qua  = {x[15], y[15], sw};
    cor  = {4'(n), b[9:7]};
  endfunction

  // A reset seen at a falling edge was sampled at the preceding rising edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      rq.delete();
      wq.delete();
      busy_until = cyc - 1;
      prev_wen   = 1'b0;
    end
    if (mon_on) begin
      chk("in_ready", 32'(in_ready), 32'(cyc > busy_until));
      if (rom_en) begin
        if (rq.size() == 0) chk("spurious_rom_en", 32'(rom_en), 0);
        else begin
          e = rq.pop_front();
          rom_cnt++;
          chk("rom_addr", 32'(rom_addr), 32'(e.addr));
          chk("rom_en_lat", 32'(cyc - e.acc), 32'(e.n + 2));
        end
      end
      if (wen) begin
        if (wq.size() == 0) chk("spurious_wen", 32'(wen), 0);
        else begin
          e = wq.pop_front();
          wen_cnt++;
          chk("index_qua", 32'(index_qua), 32'(e.qua));
          chk("index_cor", 32'(index_cor), 32'(e.cor));
          chk("wen_lat", 32'(cyc - e.acc), 32'(e.n + 2 + ROM_LAT));
          last_qua = e.qua;
          last_cor = e.cor;
        end
      end else if (prev_wen) begin
        chk("qua_hold", 32'(index_qua), 32'(last_qua));
        chk("cor_hold", 32'(index_cor), 32'(last_cor));
      end
      prev_wen = wen;
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [9:0] addr,
                      input logic [2:0] qua, input logic [6:0] cor, input int n);
    exp_t e;
    int   t;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    x_in     = x;
    y_in     = y;
    t        = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 1);
    else begin
      e.acc  = cyc + 1;
      e.n    = n;
      e.addr = addr;
      e.qua  = qua;
      e.cor  = cor;
      rq.push_back(e);
      wq.push_back(e);
      busy_until = cyc + 1 + n + 1;
    end
    @(posedge clk);
  endtask

  task automatic send_model(input logic [15:0] x, input logic [15:0] y);
    logic [9:0] addr;
    logic [2:0] qua;
    logic [6:0] cor;
    int         n;
    model(x, y, addr, qua, cor, n);
    send(x, y, addr, qua, cor, n);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    #1 in_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((rq.size() != 0 || wq.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(rq.size() + wq.size()), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rom_en"}, 32'(rom_en), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_wen"}, 32'(wen), 0);
    chk({tag, "_qua"}, 32'(index_qua), 0);
    chk({tag, "_cor"}, 32'(index_cor), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r0, w0;
    logic [15:0] rx, ry;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    chk_reset_outputs("rst");
    busy_until = cyc;
    mon_on     = 1'b1;

    // Directed patterns with hand-derived expectations
    send(16'h4000, 16'h1000, 10'h204, 3'b000, 7'h00, 0);
    idle(4);
    send(16'hFF00, 16'h0300, 10'h308, 3'b101, 7'h28, 5);
    idle(4);
    send(16'h8000, 16'h0000, 10'h3E0, 3'b100, 7'h00, 0);
    idle(4);
    send(16'h0000, 16'h0000, 10'h000, 3'b000, 7'h00, 0);
    idle(4);
    drain("drain_directed");

    // in_valid held high across three samples
    r0 = rom_cnt;
    w0 = wen_cnt;
    send(16'h4000, 16'h1000, 10'h204, 3'b000, 7'h00, 0);
    send(16'hFF00, 16'h0300, 10'h308, 3'b101, 7'h28, 5);
    send(16'h8000, 16'h0000, 10'h3E0, 3'b100, 7'h00, 0);
    idle(2);
    drain("drain_b2b");
    chk("b2b_rom_pulses", 32'(rom_cnt - r0), 3);
    chk("b2b_wen_pulses", 32'(wen_cnt - w0), 3);

    // Corners: equal magnitudes, maximal shift, double saturation, swap on tiny y
    send_model(16'h7FFF, 16'h7FFF);
    send_model(16'h0001, 16'h0000);
    send_model(16'h8000, 16'h8000);
    send_model(16'h0000, 16'hFFFF);
    send_model(16'hC000, 16'h4000);
    idle(1);
    for (int i = 0; i < 16; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rx = $signed(rx) >>> $urandom_range(0, 15);
      ry = $signed(ry) >>> $urandom_range(0, 15);
      send_model(rx, ry);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    idle(2);
    drain("drain_random");

    // Reset in the middle of normalisation
    send(16'hFF00, 16'h0300, 10'h308, 3'b101, 7'h28, 5);
    @(negedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    chk_reset_outputs("rst_norm");
    repeat (12) @(negedge clk);

    // Reset one cycle after ISSUE, with the ROM read already launched
    send(16'h4000, 16'h1000, 10'h204, 3'b000, 7'h00, 0);
    @(negedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    chk_reset_outputs("rst_post");
    repeat (12) @(negedge clk);

    send(16'h8000, 16'h0000, 10'h3E0, 3'b100, 7'h00, 0);
    idle(2);
    drain("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
